// File: rtl/pps_timekeeper.sv
// pps_timekeeper
//   Time-of-day keeper for the ptp_clk domain. Tracks seconds / milliseconds /
//   cycles-within-millisecond from the receiver's 1PPS pulse and 1 kHz tick,
//   runs in holdover when PPS goes missing, and timestamps fabric events.
//
// Ports
//   ptp_clk, ptp_rstn               clock, async active-low reset
//   pps_in, ts_in                   one-cycle 1PPS pulse and 1 kHz tick
//   evt_in                          one-cycle event strobe to timestamp
//   sec_load_valid/ready/value      seconds load, applied at the next PPS
//   ts_valid/ready, ts_sec/ms/sub   captured event timestamp (valid/ready)
//   cur_sec, cur_ms                 live time
//   locked                          two consecutive good PPS intervals seen
//   pps_missing, evt_overflow       sticky flags, cleared by status_clr
//
// Build option
//   PPS_TIMEKEEPER_EVT_FIFO_EN : event holding register becomes a 4-entry FIFO.
module pps_timekeeper #(
  parameter int C_CLOCK_FREQUENCY = 25000000,
  parameter int C_MS_PER_SEC      = 1000,
  parameter int C_SEC_WIDTH       = 32,
  localparam int SUB_W = $clog2(C_CLOCK_FREQUENCY / 1000),
  localparam int MS_W  = $clog2(C_MS_PER_SEC)
) (
  input  logic                   ptp_clk,
  input  logic                   ptp_rstn,
  input  logic                   pps_in,
  input  logic                   ts_in,
  input  logic                   evt_in,
  input  logic                   sec_load_valid,
  output logic                   sec_load_ready,
  input  logic [C_SEC_WIDTH-1:0] sec_load_value,
  output logic                   ts_valid,
  input  logic                   ts_ready,
  output logic [C_SEC_WIDTH-1:0] ts_sec,
  output logic [MS_W-1:0]        ts_ms,
  output logic [SUB_W-1:0]       ts_sub,
  output logic [C_SEC_WIDTH-1:0] cur_sec,
  output logic [MS_W-1:0]        cur_ms,
  output logic                   locked,
  output logic                   pps_missing,
  output logic                   evt_overflow,
  input  logic                   status_clr
);

  typedef struct packed {
    logic [C_SEC_WIDTH-1:0] sec;
    logic [MS_W-1:0]        ms;
    logic [SUB_W-1:0]       sub;
  } ts_t;

  localparam logic [SUB_W-1:0] SUB_MAX = '1;
  localparam logic [MS_W-1:0]  MS_LAST = MS_W'(C_MS_PER_SEC - 1);

  logic [C_SEC_WIDTH-1:0] r_sec;
  logic [MS_W-1:0]        r_ms;
  logic [SUB_W-1:0]       r_sub;
  logic [1:0]             r_good;
  logic                   r_locked;
  logic                   r_load_pend;
  logic [C_SEC_WIDTH-1:0] r_load_val;
  logic                   r_missing;
  logic                   r_ovf;

  logic w_ms_last, w_holdover, w_load_acc, w_drop;
  ts_t  w_cap;

  assign w_ms_last  = (r_ms == MS_LAST);
  // Tick that would roll ms past the end of a second with no PPS to close it.
  assign w_holdover = ts_in & ~pps_in & w_ms_last;
  assign w_load_acc = sec_load_valid & ~r_load_pend;
  // Events capture the pre-update values of the cycle they arrive in.
  assign w_cap      = '{sec: r_sec, ms: r_ms, sub: r_sub};

  // Time counters; PPS takes priority over a coincident tick.
  always_ff @(posedge ptp_clk or negedge ptp_rstn) begin
    if (!ptp_rstn) begin
      r_sec <= '0;
      r_ms  <= '0;
      r_sub <= '0;
    end else if (pps_in) begin
      r_sub <= '0;
      r_ms  <= '0;
      r_sec <= r_load_pend ? r_load_val : r_sec + 1'b1;
    end else if (ts_in) begin
      r_sub <= '0;
      if (w_ms_last) begin
        r_ms  <= '0;
        r_sec <= r_sec + 1'b1;
      end else begin
        r_ms <= r_ms + 1'b1;
      end
    end else if (r_sub != SUB_MAX) begin
      r_sub <= r_sub + 1'b1;
    end
  end

  // Lock: count of consecutive full-length PPS intervals, saturating at 2.
  always_ff @(posedge ptp_clk or negedge ptp_rstn) begin
    if (!ptp_rstn) begin
      r_good   <= '0;
      r_locked <= 1'b0;
    end else if (pps_in) begin
      if (w_ms_last) begin
        if (r_good != 2'd2) r_good <= r_good + 1'b1;
        r_locked <= (r_good != 2'd0);
      end else begin
        r_good   <= '0;
        r_locked <= 1'b0;
      end
    end else if (w_holdover) begin
      r_good   <= '0;
      r_locked <= 1'b0;
    end
  end

  // Seconds load: an accept can only happen with nothing pending, so a PPS in
  // the accept cycle never consumes the new value.
  always_ff @(posedge ptp_clk or negedge ptp_rstn) begin
    if (!ptp_rstn) begin
      r_load_pend <= 1'b0;
      r_load_val  <= '0;
    end else if (w_load_acc) begin
      r_load_pend <= 1'b1;
      r_load_val  <= sec_load_value;
    end else if (pps_in) begin
      r_load_pend <= 1'b0;
    end
  end

  // Sticky flags; a set in the same cycle as status_clr wins.
  always_ff @(posedge ptp_clk or negedge ptp_rstn) begin
    if (!ptp_rstn) begin
      r_missing <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_holdover)      r_missing <= 1'b1;
      else if (status_clr) r_missing <= 1'b0;
      if (w_drop)          r_ovf     <= 1'b1;
      else if (status_clr) r_ovf     <= 1'b0;
    end
  end

`ifdef PPS_TIMEKEEPER_EVT_FIFO_EN
  ts_t        r_mem [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_cnt;
  logic       w_pop, w_full, w_push;

  assign w_pop  = (r_cnt != 3'd0) & ts_ready;
  assign w_full = (r_cnt == 3'd4);
  // A pop in the same cycle frees a slot for the incoming event.
  assign w_push = evt_in & (~w_full | w_pop);
  assign w_drop = evt_in & w_full & ~w_pop;

  always_ff @(posedge ptp_clk or negedge ptp_rstn) begin
    if (!ptp_rstn) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= w_cap;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

  assign ts_valid                 = (r_cnt != 3'd0);
  assign {ts_sec, ts_ms, ts_sub}  = r_mem[r_rp];
`else
  ts_t  r_hold;
  logic r_valid;
  logic w_pop, w_load;

  assign w_pop  = r_valid & ts_ready;
  assign w_load = evt_in & (~r_valid | w_pop);
  assign w_drop = evt_in & r_valid & ~w_pop;

  always_ff @(posedge ptp_clk or negedge ptp_rstn) begin
    if (!ptp_rstn) begin
      r_hold  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_hold  <= w_cap;
      r_valid <= 1'b1;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign ts_valid                = r_valid;
  assign {ts_sec, ts_ms, ts_sub} = r_hold;
`endif

  assign cur_sec        = r_sec;
  assign cur_ms         = r_ms;
  assign locked         = r_locked;
  assign sec_load_ready = ~r_load_pend;
  assign pps_missing    = r_missing;
  assign evt_overflow   = r_ovf;

endmodule

// File: tb/tb_pps_timekeeper.sv
module tb_pps_timekeeper;
  localparam int CLK_HZ = 100000;           // SUB_W = 7 so saturation is reachable
  localparam int MSPS   = 1000;
  localparam int SW     = 32;
  localparam int SUB_W  = $clog2(CLK_HZ / 1000);
  localparam int MS_W   = $clog2(MSPS);
  localparam int SUBMAX = (1 << SUB_W) - 1;
`ifdef PPS_TIMEKEEPER_EVT_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic ptp_clk = 0, ptp_rstn = 0;
  logic pps_in = 0, ts_in = 0, evt_in = 0, sec_load_valid = 0, ts_ready = 0, status_clr = 0;
  logic [SW-1:0] sec_load_value = '0;
  logic sec_load_ready, ts_valid, locked, pps_missing, evt_overflow;
  logic [SW-1:0] ts_sec, cur_sec;
  logic [MS_W-1:0] ts_ms, cur_ms;
  logic [SUB_W-1:0] ts_sub;

  pps_timekeeper #(.C_CLOCK_FREQUENCY(CLK_HZ), .C_MS_PER_SEC(MSPS), .C_SEC_WIDTH(SW)) dut (
    .ptp_clk(ptp_clk), .ptp_rstn(ptp_rstn), .pps_in(pps_in), .ts_in(ts_in), .evt_in(evt_in),
    .sec_load_valid(sec_load_valid), .sec_load_ready(sec_load_ready), .sec_load_value(sec_load_value),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_sec(ts_sec), .ts_ms(ts_ms), .ts_sub(ts_sub),
    .cur_sec(cur_sec), .cur_ms(cur_ms), .locked(locked), .pps_missing(pps_missing),
    .evt_overflow(evt_overflow), .status_clr(status_clr));

  always #5 ptp_clk = ~ptp_clk;

  int errors = 0, checks = 0;
  bit rdy = 0;

  // Behavioural model: time-of-day as plain numbers, event store as a queue.
  typedef struct { logic [SW-1:0] sec; int ms; int sub; } mts_t;
  logic [SW-1:0] m_sec, m_pval;
  int   m_ms, m_sub, m_good;
  bit   m_pend, m_miss, m_ovf;
  mts_t m_q[$];

  task automatic model_reset();
    m_sec = 0; m_ms = 0; m_sub = 0; m_good = 0; m_pend = 0; m_pval = 0;
    m_miss = 0; m_ovf = 0; m_q.delete();
  endtask

  task automatic model_step(input bit p, t, e, lv, input logic [SW-1:0] lval, input bit r, clr);
    mts_t cap; bit drop, hold, acc;
    cap = '{m_sec, m_ms, m_sub};
    drop = 0;
    if (m_q.size() > 0 && r) void'(m_q.pop_front());
    if (e) begin
      if (m_q.size() < DEPTH) m_q.push_back(cap); else drop = 1;
    end
    acc  = lv && !m_pend;
    hold = t && !p && (m_ms == MSPS - 1);
    if (p) begin
      m_good = (m_ms == MSPS - 1) ? ((m_good >= 2) ? 2 : m_good + 1) : 0;
      m_sec  = m_pend ? m_pval : m_sec + 1;
      m_pend = 0; m_ms = 0; m_sub = 0;
    end else if (t) begin
      m_sub = 0;
      if (hold) begin m_ms = 0; m_sec = m_sec + 1; m_good = 0; end
      else m_ms = m_ms + 1;
    end else if (m_sub < SUBMAX) m_sub = m_sub + 1;
    if (acc) begin m_pend = 1; m_pval = lval; end
    if (clr) begin m_miss = 0; m_ovf = 0; end
    if (hold) m_miss = 1;
    if (drop) m_ovf = 1;
  endtask

  // One clock: drive at negedge, advance the model, sample 1 time unit after posedge.
  task automatic step(input bit p, t, e, lv, input logic [SW-1:0] lval, input bit clr);
    @(negedge ptp_clk);
    pps_in = p; ts_in = t; evt_in = e; sec_load_valid = lv; sec_load_value = lval;
    status_clr = clr; ts_ready = rdy;
    model_step(p, t, e, lv, lval, rdy, clr);
    @(posedge ptp_clk); #1;
    pps_in = 0; ts_in = 0; evt_in = 0; sec_load_valid = 0; status_clr = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(1, 0) == 1) step(0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
    end
  endtask

  task automatic test_reset();
    ptp_rstn = 0; rdy = 0; model_reset();
    #23;
    checks++; if (cur_sec !== 0 || cur_ms !== 0) begin errors++; $display("FAIL rst_cur: got sec=%0h ms=%0d want 0 0", cur_sec, cur_ms); end
    checks++; if (ts_valid !== 0 || ts_sec !== 0 || ts_ms !== 0 || ts_sub !== 0) begin errors++; $display("FAIL rst_ts: got v=%b %0h/%0d/%0d want all 0", ts_valid, ts_sec, ts_ms, ts_sub); end
    checks++; if (sec_load_ready !== 1 || locked !== 0 || pps_missing !== 0 || evt_overflow !== 0) begin errors++; $display("FAIL rst_flags: got rdy=%b lk=%b miss=%b ovf=%b want 1 0 0 0", sec_load_ready, locked, pps_missing, evt_overflow); end
    @(posedge ptp_clk); #1; ptp_rstn = 1;
  endtask

  task automatic test_lock();
    for (int s = 0; s < 3; s++) begin
      ticks(MSPS - 1);
      checks++; if (cur_ms !== MS_W'(MSPS - 1)) begin errors++; $display("FAIL lock_ms: got %0d want %0d", cur_ms, MSPS - 1); end
      step(1, 1, 0, 0, 0, 0);
      checks++; if (cur_sec !== SW'(s + 1) || cur_sec !== m_sec) begin errors++; $display("FAIL lock_sec: got %0d want %0d", cur_sec, s + 1); end
      checks++; if (locked !== (s >= 1) || pps_missing !== 0 || cur_ms !== 0) begin errors++; $display("FAIL lock_state: got lk=%b miss=%b ms=%0d want %b 0 0", locked, pps_missing, cur_ms, s >= 1); end
    end
  endtask

  task automatic test_holdover();
    ticks(MSPS - 1);
    step(0, 1, 0, 0, 0, 0);
    checks++; if (cur_sec !== 4 || cur_ms !== 0) begin errors++; $display("FAIL hold_time: got sec=%0d ms=%0d want 4 0", cur_sec, cur_ms); end
    checks++; if (pps_missing !== 1 || locked !== 0) begin errors++; $display("FAIL hold_flags: got miss=%b lk=%b want 1 0", pps_missing, locked); end
    step(0, 0, 0, 0, 0, 1);
    checks++; if (pps_missing !== 0) begin errors++; $display("FAIL hold_clr: got %b want 0", pps_missing); end
  endtask

  task automatic test_load();
    ticks(500);
    step(0, 0, 0, 1, 32'h5A5A0000, 0);
    checks++; if (sec_load_ready !== 0) begin errors++; $display("FAIL ld_ready_fall: got %b want 0", sec_load_ready); end
    ticks(MSPS - 1 - m_ms);
    checks++; if (cur_sec !== 4) begin errors++; $display("FAIL ld_hold_sec: got %0h want 4", cur_sec); end
    step(1, 1, 0, 0, 0, 0);
    checks++; if (cur_sec !== 32'h5A5A0000 || sec_load_ready !== 1) begin errors++; $display("FAIL ld_apply: got sec=%0h rdy=%b want 5a5a0000 1", cur_sec, sec_load_ready); end
    step(1, 1, 0, 1, 32'h11110000, 0);
    checks++; if (cur_sec !== 32'h5A5A0001 || sec_load_ready !== 0) begin errors++; $display("FAIL ld_same_pps: got sec=%0h rdy=%b want 5a5a0001 0", cur_sec, sec_load_ready); end
    ticks(20);
    step(1, 0, 0, 0, 0, 0);
    checks++; if (cur_sec !== 32'h11110000 || sec_load_ready !== 1) begin errors++; $display("FAIL ld_next_pps: got sec=%0h rdy=%b want 11110000 1", cur_sec, sec_load_ready); end
  endtask

  task automatic test_evt_pps();
    rdy = 0;
    step(0, 0, 0, 1, 32'd7, 0);
    step(1, 1, 0, 0, 0, 0);
    ticks(MSPS - 1);
    step(1, 1, 1, 0, 0, 0);
    checks++; if (ts_valid !== 1 || ts_sec !== 7 || ts_ms !== MS_W'(MSPS - 1)) begin errors++; $display("FAIL evt_pps_ts: got v=%b sec=%0d ms=%0d want 1 7 999", ts_valid, ts_sec, ts_ms); end
    checks++; if (cur_sec !== 8 || ts_sub !== SUB_W'(m_q[0].sub)) begin errors++; $display("FAIL evt_pps_cur: got sec=%0d sub=%0d want 8 %0d", cur_sec, ts_sub, m_q[0].sub); end
    rdy = 1; step(0, 0, 0, 0, 0, 0);
    checks++; if (ts_valid !== 0) begin errors++; $display("FAIL evt_drain: got %b want 0", ts_valid); end
  endtask

  task automatic test_overflow();
    rdy = 0;
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    checks++; if (ts_valid !== 1 || ts_sub !== 0 || ts_sub !== SUB_W'(m_q[0].sub)) begin errors++; $display("FAIL ovf_first: got v=%b sub=%0d want 1 0", ts_valid, ts_sub); end
`ifdef PPS_TIMEKEEPER_EVT_FIFO_EN
    checks++; if (evt_overflow !== 0) begin errors++; $display("FAIL ovf_flag: got %b want 0", evt_overflow); end
    rdy = 1; step(0, 0, 0, 0, 0, 0);
    checks++; if (ts_valid !== 1 || ts_sub !== 5) begin errors++; $display("FAIL ovf_second: got v=%b sub=%0d want 1 5", ts_valid, ts_sub); end
`else
    checks++; if (evt_overflow !== 1) begin errors++; $display("FAIL ovf_flag: got %b want 1", evt_overflow); end
    rdy = 1;
`endif
    step(0, 0, 0, 0, 0, 1);
    checks++; if (ts_valid !== 0 || evt_overflow !== 0) begin errors++; $display("FAIL ovf_clr: got v=%b ovf=%b want 0 0", ts_valid, evt_overflow); end
  endtask

  task automatic test_saturate();
    rdy = 1;
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < SUBMAX + 10; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    checks++; if (ts_valid !== 1 || ts_sub !== SUB_W'(SUBMAX)) begin errors++; $display("FAIL sub_sat: got v=%b sub=%0d want 1 %0d", ts_valid, ts_sub, SUBMAX); end
  endtask

  task automatic test_back_to_back();
    rdy = 1;
    for (int i = 0; i < 6; i++) begin
      step(0, (i == 3), 1, 0, 0, 0);
      checks++; if (ts_valid !== 1 || ts_sub !== SUB_W'(m_q[0].sub) || ts_ms !== MS_W'(m_q[0].ms) || evt_overflow !== 0) begin
        errors++; $display("FAIL b2b_%0d: got v=%b ms=%0d sub=%0d ovf=%b want 1 %0d %0d 0", i, ts_valid, ts_ms, ts_sub, evt_overflow, m_q[0].ms, m_q[0].sub); end
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit p, t, e, lv, clr; logic [SW-1:0] v;
    for (int i = 0; i < 3000; i++) begin
      p = ($urandom_range(999, 0) < 2); t = ($urandom_range(1, 0) == 1);
      e = ($urandom_range(3, 0) == 0); lv = ($urandom_range(49, 0) == 0);
      clr = ($urandom_range(29, 0) == 0); v = $urandom; rdy = ($urandom_range(1, 0) == 1);
      step(p, t, e, lv, v, clr);
      checks++; if (cur_sec !== m_sec || cur_ms !== MS_W'(m_ms)) begin errors++; $display("FAIL rnd_time@%0d: got %0h/%0d want %0h/%0d", i, cur_sec, cur_ms, m_sec, m_ms); end
      checks++; if (locked !== (m_good == 2) || pps_missing !== m_miss || evt_overflow !== m_ovf || sec_load_ready !== !m_pend) begin
        errors++; $display("FAIL rnd_flags@%0d: got lk=%b miss=%b ovf=%b rdy=%b want %b %b %b %b", i, locked, pps_missing, evt_overflow, sec_load_ready, m_good == 2, m_miss, m_ovf, !m_pend); end
      checks++; if (ts_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", i, ts_valid, m_q.size() > 0); end
      else if (ts_valid && (ts_sec !== m_q[0].sec || ts_ms !== MS_W'(m_q[0].ms) || ts_sub !== SUB_W'(m_q[0].sub))) begin
        errors++; $display("FAIL rnd_ts@%0d: got %0h/%0d/%0d want %0h/%0d/%0d", i, ts_sec, ts_ms, ts_sub, m_q[0].sec, m_q[0].ms, m_q[0].sub); end
    end
  endtask

  task automatic test_reset_mid();
    rdy = 0;
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 32'hCAFE0000, 0);
    checks++; if (ts_valid !== 1 || sec_load_ready !== 0) begin errors++; $display("FAIL rmid_pre: got v=%b rdy=%b want 1 0", ts_valid, sec_load_ready); end
    #2 ptp_rstn = 0; model_reset();
    #1;
    checks++; if (ts_valid !== 0 || ts_sec !== 0 || ts_ms !== 0 || ts_sub !== 0 || cur_sec !== 0 || cur_ms !== 0) begin
      errors++; $display("FAIL rmid_zero: got v=%b ts=%0h/%0d/%0d cur=%0h/%0d want all 0", ts_valid, ts_sec, ts_ms, ts_sub, cur_sec, cur_ms); end
    checks++; if (sec_load_ready !== 1 || locked !== 0 || pps_missing !== 0 || evt_overflow !== 0) begin errors++; $display("FAIL rmid_flags: got rdy=%b lk=%b miss=%b ovf=%b want 1 0 0 0", sec_load_ready, locked, pps_missing, evt_overflow); end
    @(posedge ptp_clk); #1; ptp_rstn = 1;
    step(1, 0, 0, 0, 0, 0);
    checks++; if (cur_sec !== 1 || sec_load_ready !== 1) begin errors++; $display("FAIL rmid_after: got sec=%0h rdy=%b want 1 1", cur_sec, sec_load_ready); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_holdover();
    test_load();
    test_evt_pps();
    test_overflow();
    test_saturate();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
